// File: rtl/mips_cpu_harvard.sv
// mips_cpu_harvard: single-cycle MIPS32 subset core with
// separate instruction and data ports and a run/halt flag.
module mips_cpu_harvard #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  logic [31:0] pc;
  logic [31:0] gpr [32];

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic [4:0]  rd_a;
  logic [4:0]  sh;
  logic [15:0] imm;
  logic [31:0] rs_v;
  logic [31:0] rt_v;
  logic [31:0] sext;
  logic [31:0] zext;
  logic [31:0] pc4;
  logic [31:0] jtgt;
  logic [31:0] mem_addr;

  logic        wr_en;
  logic [4:0]  wr_a;
  logic [31:0] wr_d;
  logic [31:0] next_pc;
  logic        is_lw;
  logic        is_sw;
  logic        unused_ok;

  assign unused_ok = clk_enable;

  assign op   = instr_readdata[31:26];
  assign rs_a = instr_readdata[25:21];
  assign rt_a = instr_readdata[20:16];
  assign rd_a = instr_readdata[15:11];
  assign sh   = instr_readdata[10:6];
  assign fn   = instr_readdata[5:0];
  assign imm  = instr_readdata[15:0];

  assign rs_v = (rs_a == 5'd0) ? '0 : gpr[rs_a];
  assign rt_v = (rt_a == 5'd0) ? '0 : gpr[rt_a];
  assign sext = {{16{imm[15]}}, imm};
  assign zext = {16'h0000, imm};
  assign pc4  = pc + 32'd4;
  assign jtgt = {pc[31:28], instr_readdata[25:0], 2'b00};
  assign mem_addr = rs_v + sext;

  always_comb begin
    wr_en   = 1'b0;
    wr_a    = rt_a;
    wr_d    = '0;
    next_pc = pc4;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    unique case (op)
      OP_R: begin
        wr_en = 1'b1;
        wr_a  = rd_a;
        unique case (fn)
          F_ADDU: wr_d = rs_v + rt_v;
          F_SUBU: wr_d = rs_v - rt_v;
          F_AND:  wr_d = rs_v & rt_v;
          F_OR:   wr_d = rs_v | rt_v;
          F_XOR:  wr_d = rs_v ^ rt_v;
          F_NOR:  wr_d = ~(rs_v | rt_v);
          F_SLT:  wr_d = {31'b0, $signed(rs_v) < $signed(rt_v)};
          F_SLTU: wr_d = {31'b0, rs_v < rt_v};
          F_SLL:  wr_d = rt_v << sh;
          F_SRL:  wr_d = rt_v >> sh;
          F_SRA:  wr_d = $signed(rt_v) >>> sh;
          F_SLLV: wr_d = rt_v << rs_v[4:0];
          F_SRLV: wr_d = rt_v >> rs_v[4:0];
          F_SRAV: wr_d = $signed(rt_v) >>> rs_v[4:0];
          F_JR: begin
            wr_en   = 1'b0;
            next_pc = rs_v;
          end
          F_JALR: begin
            wr_d    = pc4;
            next_pc = rs_v;
          end
          default: wr_en = 1'b0;
        endcase
      end
      OP_J: next_pc = jtgt;
      OP_JAL: begin
        next_pc = jtgt;
        wr_en   = 1'b1;
        wr_a    = 5'd31;
        wr_d    = pc4;
      end
      // branch offset is a byte offset, no shift
      OP_BEQ: if (rs_v == rt_v) next_pc = pc + sext;
      OP_BNE: if (rs_v != rt_v) next_pc = pc + sext;
      OP_ADDIU: begin
        wr_en = 1'b1;
        wr_d  = rs_v + sext;
      end
      OP_SLTI: begin
        wr_en = 1'b1;
        wr_d  = {31'b0, $signed(rs_v) < $signed(sext)};
      end
      OP_SLTIU: begin
        wr_en = 1'b1;
        wr_d  = {31'b0, rs_v < sext};
      end
      OP_ANDI: begin
        wr_en = 1'b1;
        wr_d  = rs_v & zext;
      end
      OP_ORI: begin
        wr_en = 1'b1;
        wr_d  = rs_v | zext;
      end
      OP_XORI: begin
        wr_en = 1'b1;
        wr_d  = rs_v ^ zext;
      end
      OP_LUI: begin
        wr_en = 1'b1;
        wr_d  = {imm, 16'h0000};
      end
      OP_LW: begin
        wr_en = 1'b1;
        is_lw = 1'b1;
        wr_d  = data_readdata;
      end
      OP_SW: is_sw = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_VECTOR;
      active <= 1'b1;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (active) begin
      pc     <= next_pc;
      active <= (next_pc != 32'h0);
      if (wr_en && wr_a != 5'd0) gpr[wr_a] <= wr_d;
    end
  end

  assign instr_address  = pc;
  assign register_v0    = gpr[2];
  assign data_read      = active & is_lw;
  // a store on the reset edge must not reach memory
  assign data_write     = active & is_sw & ~reset;
  assign data_address   = (active & (is_lw | is_sw)) ? mem_addr : '0;
  assign data_writedata = (active & is_sw) ? rt_v : '0;

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// tb_mips_cpu_harvard: directed and random programs checked
// against an instruction-level reference model.
module tb_mips_cpu_harvard;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] EXPA [7] = '{
    32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC00088,
    32'hBFC0008C, 32'hBFC00010, 32'hBFC00008
  };
  localparam logic [5:0] FNS [14] = '{
    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
    6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07
  };
  localparam logic [5:0] IOPS [7] = '{
    6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f
  };
  localparam logic [5:0] BADOPS [3] = '{6'h3e, 6'h20, 6'h28};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  logic [31:0] fill = 32'h0;
  logic [31:0] ioff;

  logic [31:0] m_pc;
  logic [31:0] m_reg [32];
  logic        m_active;
  logic [31:0] m_dmem [16];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_cpu_harvard #(.RESET_VECTOR(RV)) dut (
    .clk(clk),
    .reset(reset),
    .active(active),
    .register_v0(register_v0),
    .clk_enable(clk_enable),
    .instr_address(instr_address),
    .instr_readdata(instr_readdata),
    .data_address(data_address),
    .data_write(data_write),
    .data_read(data_read),
    .data_writedata(data_writedata),
    .data_readdata(data_readdata)
  );

  assign ioff = instr_address - RV;
  assign instr_readdata =
    (ioff < 32'd256 && ioff[1:0] == 2'b00) ? imem[ioff[7:2]] : fill;
  assign data_readdata = dmem[data_address[5:2]];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] fetch(input logic [31:0] a);
    logic [31:0] o;
    o = a - RV;
    if (o < 32'd256 && o[1:0] == 2'b00) return imem[o[7:2]];
    return fill;
  endfunction

  function automatic logic [31:0] sra(input logic [31:0] v,
                                      input logic [4:0] n);
    logic [31:0] hi;
    hi = v[31] ? ~(32'hFFFFFFFF >> n) : 32'h0;
    return (v >> n) | hi;
  endfunction

  task automatic model_reset();
    m_pc = RV;
    m_active = 1'b1;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
  endtask

  // Executes the instruction at m_pc; returns its memory-port activity.
  task automatic model_step(output logic dw, output logic dr,
                            output logic [31:0] da,
                            output logic [31:0] dd);
    logic [31:0] ins, s, t, se, ze, nx, res;
    logic        we;
    logic [4:0]  d;
    ins = fetch(m_pc);
    s   = m_reg[ins[25:21]];
    t   = m_reg[ins[20:16]];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0, ins[15:0]};
    nx  = m_pc + 32'd4;
    we  = 1'b0;
    d   = ins[20:16];
    res = 32'h0;
    dw = 1'b0; dr = 1'b0; da = 32'h0; dd = 32'h0;
    case (ins[31:26])
      6'h00: begin
        d = ins[15:11];
        we = 1'b1;
        case (ins[5:0])
          6'h21: res = s + t;
          6'h23: res = s - t;
          6'h24: res = s & t;
          6'h25: res = s | t;
          6'h26: res = s ^ t;
          6'h27: res = ~(s | t);
          6'h2a: res = ($signed(s) < $signed(t)) ? 32'd1 : 32'd0;
          6'h2b: res = (s < t) ? 32'd1 : 32'd0;
          6'h00: res = t << ins[10:6];
          6'h02: res = t >> ins[10:6];
          6'h03: res = sra(t, ins[10:6]);
          6'h04: res = t << s[4:0];
          6'h06: res = t >> s[4:0];
          6'h07: res = sra(t, s[4:0]);
          6'h08: begin we = 1'b0; nx = s; end
          6'h09: begin res = m_pc + 32'd4; nx = s; end
          default: we = 1'b0;
        endcase
      end
      6'h02: nx = {m_pc[31:28], ins[25:0], 2'b00};
      6'h03: begin
        nx = {m_pc[31:28], ins[25:0], 2'b00};
        we = 1'b1; d = 5'd31; res = m_pc + 32'd4;
      end
      6'h04: if (s == t) nx = m_pc + se;
      6'h05: if (s != t) nx = m_pc + se;
      6'h09: begin we = 1'b1; res = s + se; end
      6'h0a: begin
        we = 1'b1;
        res = ($signed(s) < $signed(se)) ? 32'd1 : 32'd0;
      end
      6'h0b: begin we = 1'b1; res = (s < se) ? 32'd1 : 32'd0; end
      6'h0c: begin we = 1'b1; res = s & ze; end
      6'h0d: begin we = 1'b1; res = s | ze; end
      6'h0e: begin we = 1'b1; res = s ^ ze; end
      6'h0f: begin we = 1'b1; res = {ins[15:0], 16'h0}; end
      6'h23: begin
        we = 1'b1; dr = 1'b1; da = s + se;
        res = m_dmem[da[5:2]];
      end
      6'h2b: begin dw = 1'b1; da = s + se; dd = t; end
      default: ;
    endcase
    if (!m_active) begin
      dw = 1'b0;
    end else begin
      if (we && d != 5'd0) m_reg[d] = res;
      if (dw) m_dmem[da[5:2]] = dd;
      m_pc = nx;
      if (nx == 32'h0) m_active = 1'b0;
    end
  endtask

  task automatic cycle();
    logic dw, dr, was;
    logic [31:0] da, dd;
    @(negedge clk);
    was = m_active;
    check("pc", instr_address, m_pc);
    check("active", 32'(active), 32'(m_active));
    check("v0", register_v0, m_reg[2]);
    model_step(dw, dr, da, dd);
    check("dwrite", 32'(data_write), 32'(dw));
    if (was) begin
      check("dread", 32'(data_read), 32'(dr));
      check("daddr", data_address, da);
      check("wdata", data_writedata, dd);
    end
    if (data_write) dmem[data_address[5:2]] = data_writedata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  function automatic logic [4:0] rreg();
    logic [2:0] r;
    r = 3'($urandom_range(0, 7));
    return (r == 3'd7) ? 5'd31 : {2'b00, r};
  endfunction

  function automatic logic [31:0] rnd_instr(input int idx);
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [31:0] tgt;
    int          k, t;
    rs  = rreg();
    rt  = rreg();
    rd  = rreg();
    sh  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    k   = int'($urandom_range(0, 19));
    t   = int'($urandom_range(0, 49));
    tgt = RV + 32'(t * 4);
    if (k <= 5)
      return {6'h00, rs, rt, rd, sh, FNS[$urandom_range(0, 13)]};
    if (k == 6)
      return {6'h00, rs, rt, rd, sh, 6'h3f};
    if (k <= 12)
      return {IOPS[$urandom_range(0, 6)], rs, rt, imm};
    if (k == 13)
      return {6'h23, rs, rt, 16'($urandom_range(0, 63))};
    if (k == 14)
      return {6'h2b, rs, rt, 16'($urandom_range(0, 63))};
    if (k <= 16)
      return {(k == 15) ? 6'h04 : 6'h05, rs, rt, 16'((t - idx) * 4)};
    if (k == 17)
      return {($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03, tgt[27:2]};
    if (k == 18)
      return {BADOPS[$urandom_range(0, 2)], rs, rt, imm};
    return {6'h00, rs, 5'd0, 5'd2, 5'd0, 6'h21};
  endfunction

  initial begin
    clear_imem();
    for (int i = 0; i < 16; i++) begin
      dmem[i] = 32'h0;
      m_dmem[i] = 32'h0;
    end
    model_reset();

    // branches: taken forward, not taken, jump, negative offset
    imem[0]  = 32'h24010020;
    imem[1]  = 32'h24030020;
    imem[2]  = 32'h14600080;
    imem[34] = 32'h14610080;
    imem[35] = 32'h0BF00004;
    imem[4]  = 32'h1023FFF8;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle();
      check("br_fetch", instr_address, EXPA[i]);
    end

    // store, load, then halt through JR $0
    clear_imem();
    imem[0] = 32'h24020005;
    imem[1] = 32'hAC020004;
    imem[2] = 32'h8C040004;
    imem[3] = 32'h24820002;
    imem[4] = 32'h00000008;
    fill = 32'h24020009;
    do_reset();
    cycle();
    check("reset_pc", instr_address, RV);
    check("reset_v0", register_v0, 32'h0);
    cycle();
    check("sw_v0", register_v0, 32'd5);
    check("sw_we", 32'(data_write), 32'd1);
    check("sw_addr", data_address, 32'd4);
    check("sw_data", data_writedata, 32'd5);
    cycle();
    check("lw_re", 32'(data_read), 32'd1);
    check("lw_addr", data_address, 32'd4);
    check("lw_rdata", data_readdata, 32'd5);
    cycle();
    cycle();
    check("jr_v0", register_v0, 32'd7);
    check("jr_active", 32'(active), 32'd1);
    cycle();
    check("halt_active", 32'(active), 32'd0);
    check("halt_pc", instr_address, 32'h0);
    cycle();
    cycle();
    check("halt_v0", register_v0, 32'd7);
    fill = 32'hAC020000;
    cycle();
    check("halt_nowrite", 32'(data_write), 32'd0);
    cycle();

    // reset mid-program while $2 = 7
    do_reset();
    repeat (5) cycle();
    check("mid_v0", register_v0, 32'd7);
    do_reset();
    cycle();
    check("mid_pc", instr_address, RV);
    check("mid_v0z", register_v0, 32'h0);
    check("mid_active", 32'(active), 32'd1);

    // JALR link and arithmetic shift of a negative value
    clear_imem();
    imem[0] = 32'h3C05BFC0;
    imem[1] = 32'h34A50010;
    imem[2] = 32'h00A01009;
    imem[3] = 32'h24020001;
    imem[4] = 32'h00021103;
    imem[5] = 32'h00000008;
    fill = 32'h0;
    do_reset();
    repeat (4) cycle();
    check("jalr_pc", instr_address, RV + 32'h10);
    check("jalr_link", register_v0, RV + 32'hC);
    cycle();
    check("sra_v0", register_v0, 32'hFBFC0000);
    repeat (3) cycle();

    // random programs ending in ADDIU $2,$0,7 ; JR $0
    for (int it = 0; it < 12; it++) begin
      clear_imem();
      for (int i = 0; i < 48; i++) imem[i] = rnd_instr(i);
      imem[48] = 32'h24020007;
      imem[49] = 32'h00000008;
      for (int i = 0; i < 16; i++) begin
        dmem[i] = $urandom;
        m_dmem[i] = dmem[i];
      end
      fill = ($urandom_range(0, 1) == 0) ? 32'hAC020000 : 32'h24020009;
      do_reset();
      repeat ($urandom_range(30, 160)) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
